ecc_encoding_wr: RTL and testbench
==================================

// Module: ecc_encoding_wr
// PURPOSE
//  Write-path ECC encoder; the encoding counterpart of the ECC read-path decoder. It sits
//  between the AXI write channel logic and the 39-bit ECC memory.
//  - Accepts 32-bit writes with byte strobes and computes a 7-bit SEC-DED Hamming code.
//  - Writes the 39-bit codeword to memory.
//  - Partial-strobe writes use a read-modify-write sequence, because the parity covers the whole word.
// PARAMETERS
//  DATA_WIDTH        32  data word width
//  MEMORY_DATA_WIDTH 39  stored codeword width (DATA_WIDTH + PARITY_BITS + 1)
//  ADDR_WIDTH        14  byte address width on the write-request side
//  PARITY_BITS       6   Hamming parity bits; one extra overall-parity bit is added
// PORTS
//  ECC_encoding_clk    in   1   clock
//  ECC_encoding_rst    in   1   synchronous, active-high reset
//  ECC_en              in   32  bit0=1: encode parity; bit0=0: parity/overall bits written as 0
//  wr_en_i             in   1   write request valid
//  wr_ready_o          out  1   request accepted when wr_en_i & wr_ready_o
//  wr_addr_i           in   14  byte address; bits [1:0] ignored
//  wr_data_i           in   32  write data
//  wr_strb_i           in   4   byte strobes; bit n covers wr_data_i[8n+7:8n]
//  mem_rd_en_o         out  1   memory read strobe (RMW only)
//  mem_wr_en_o         out  1   memory write strobe
//  mem_addr_o          out  12  word address = wr_addr_i[13:2]
//  mem_rd_data_i       in   39  memory read codeword, valid the cycle after mem_rd_en_o
//  mem_wr_data_o       out  39  encoded codeword
//  wr_done_o           out  1   one-cycle pulse when a request completes (incl. strb==0)
// BEHAVIOUR
//  Codeword layout
//  - Bit k of the codeword holds Hamming position k (k=1..38).
//  - Parity bit p_i sits at position 2^i (i=0..5) and is the XOR of all positions with bit i set.
//  - Data bits d0..d31 fill the non-power-of-two positions in ascending order (d0 at pos 3).
//  - Bit 0 is overall parity = XOR of bits [38:1].
//  Request capture
//  - On acceptance, addr/data/strb and ECC_en[0] are registered.
//  - Changes to ECC_en mid-operation do not affect the request in flight.
//  FSM states: IDLE, RD, MERGE, WRITE
//  - wr_ready_o = (state==IDLE).
//  - IDLE: accept; strb==4'hF -> WRITE; strb==4'h0 -> stay IDLE, pulse wr_done_o next cycle, no memory access.
//  - IDLE: any other strb -> RD.
//  - RD: mem_rd_en_o=1 for one cycle -> MERGE.
//  - MERGE: capture mem_rd_data_i and extract the old data from the data positions (no correction applied).
//    Replace the strobed bytes, then re-encode -> WRITE.
//  - WRITE: mem_wr_en_o=1 and wr_done_o=1 for one cycle; mem_wr_data_o is valid -> IDLE.
//  Latency (accept at cycle N)
//  - Full write: mem_wr_en_o at N+1; ready again at N+2.
//  - RMW: mem_rd_en_o at N+1, data captured at N+2, mem_wr_en_o at N+3, ready at N+4.
//  Strobe and address hold
//  - mem_rd_en_o and mem_wr_en_o are never both high.
//  - mem_addr_o is held stable from RD through WRITE.
//  Reset (synchronous, active-high)
//  - state=IDLE; all outputs 0 except wr_ready_o, which is 1 after the reset cycle.
//  - Reset mid-RMW abandons the request: no mem_wr_en_o and no wr_done_o follow.
//  Other rules
//  - wr_en_i while not ready is ignored; the requester must hold it.
//  - Addresses wrap naturally at 12 bits; no range check.
// TESTING
//  - Reset, then full write addr 0x0004, data 0x00000001, strb F, ECC_en=1
//    -> mem_addr_o=0x001, mem_wr_data_o=39'h0F at N+1, wr_done_o pulse.
//  - Same write with ECC_en=0 -> mem_wr_data_o=39'h08.
//  - Data 0x00000000, strb F, ECC_en=1 -> codeword 39'h0.
//  - Partial write strb 4'b0001, data 0x000000A5, mem_rd_data_i=encode(0x12345600)
//    -> mem_rd_en_o at N+1, mem_wr_data_o=encode(0x123456A5) at N+3, wr_ready_o low N+1..N+3.
//  - strb=0 -> no mem_rd_en_o/mem_wr_en_o, wr_done_o at N+1.
//  - Assert ECC_encoding_rst in MERGE -> outputs 0, no write issued, wr_ready_o=1 next cycle.
//  - Back-to-back full writes with wr_en_i held -> accepts every 2 cycles.
//  - Compare every codeword against the decoder model: syndrome 0.

Source files
------------

// File: rtl/ecc_encoding_wr_if.sv
// Write-request and ECC-memory signal bundle for the write-path ECC encoder.
// The master side is the requester plus memory; the slave side is the encoder.
interface ecc_encoding_wr_if;
  localparam int unsigned DATA_WIDTH        = 32;
  localparam int unsigned MEMORY_DATA_WIDTH = 39;
  localparam int unsigned ADDR_WIDTH        = 14;
  localparam int unsigned WORD_ADDR_WIDTH   = ADDR_WIDTH - 2;
  localparam int unsigned STRB_WIDTH        = DATA_WIDTH / 8;

  logic                         wr_en_i;
  logic                         wr_ready_o;
  logic [ADDR_WIDTH-1:0]        wr_addr_i;
  logic [DATA_WIDTH-1:0]        wr_data_i;
  logic [STRB_WIDTH-1:0]        wr_strb_i;
  logic                         mem_rd_en_o;
  logic                         mem_wr_en_o;
  logic [WORD_ADDR_WIDTH-1:0]   mem_addr_o;
  logic [MEMORY_DATA_WIDTH-1:0] mem_rd_data_i;
  logic [MEMORY_DATA_WIDTH-1:0] mem_wr_data_o;
  logic                         wr_done_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, wr_strb_i, mem_rd_data_i,
    input  wr_ready_o, mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wr_data_o, wr_done_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, wr_strb_i, mem_rd_data_i,
    output wr_ready_o, mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wr_data_o, wr_done_o
  );
endinterface

// File: rtl/ecc_encoding_wr.sv
// Write-path SEC-DED encoder: full-word writes go straight to memory, partial-strobe
// writes read the old codeword, merge the strobed bytes and re-encode before writing.
module ecc_encoding_wr (
  input  logic                ECC_encoding_clk,
  input  logic                ECC_encoding_rst,
  input  logic [31:0]         ECC_en,
  ecc_encoding_wr_if.slave    bus
);
  localparam int unsigned DATA_WIDTH        = 32;
  localparam int unsigned MEMORY_DATA_WIDTH = 39;
  localparam int unsigned ADDR_WIDTH        = 14;
  localparam int unsigned PARITY_BITS       = 6;
  localparam int unsigned WORD_ADDR_WIDTH   = ADDR_WIDTH - 2;
  localparam int unsigned STRB_WIDTH        = DATA_WIDTH / 8;

  // Hamming positions covered by each parity bit p_i (positions with bit i set).
  localparam logic [MEMORY_DATA_WIDTH-1:0] MASK_P0 = 39'h2A_AAAA_AAAA;
  localparam logic [MEMORY_DATA_WIDTH-1:0] MASK_P1 = 39'h4C_CCCC_CCCC;
  localparam logic [MEMORY_DATA_WIDTH-1:0] MASK_P2 = 39'h70_F0F0_F0F0;
  localparam logic [MEMORY_DATA_WIDTH-1:0] MASK_P3 = 39'h00_FF00_FF00;
  localparam logic [MEMORY_DATA_WIDTH-1:0] MASK_P4 = 39'h00_FFFF_0000;
  localparam logic [MEMORY_DATA_WIDTH-1:0] MASK_P5 = 39'h7F_0000_0000;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_MERGE, S_WRITE} state_t;

  // Data bits occupy the non-power-of-two positions 3,5-7,9-15,17-31,33-38.
  function automatic logic [MEMORY_DATA_WIDTH-1:0] f_place(input logic [DATA_WIDTH-1:0] d);
    return {d[31:26], 1'b0, d[25:11], 1'b0, d[10:4], 1'b0, d[3:1], 1'b0, d[0], 3'b000};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] f_extract(input logic [MEMORY_DATA_WIDTH-1:0] cw);
    return {cw[38:33], cw[31:17], cw[15:9], cw[7:5], cw[3]};
  endfunction

  function automatic logic [MEMORY_DATA_WIDTH-1:0] f_encode(input logic [DATA_WIDTH-1:0] d,
                                                            input logic                  en);
    logic [MEMORY_DATA_WIDTH-1:0] cw;
    cw = f_place(d);
    if (en) begin
      cw[1]  = ^(cw & MASK_P0);
      cw[2]  = ^(cw & MASK_P1);
      cw[4]  = ^(cw & MASK_P2);
      cw[8]  = ^(cw & MASK_P3);
      cw[16] = ^(cw & MASK_P4);
      cw[32] = ^(cw & MASK_P5);
      cw[0]  = ^cw[MEMORY_DATA_WIDTH-1:1];
    end
    return cw;
  endfunction

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic                         r_ready;
  logic                         r_rd_en;
  logic                         r_wr_en;
  logic                         r_done;
  logic [WORD_ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]        r_data;
  logic [STRB_WIDTH-1:0]        r_strb;
  logic                         r_ecc_en;
  logic [MEMORY_DATA_WIDTH-1:0] r_wr_data;

  logic                         w_accept;
  logic                         w_zero_done;
  logic [DATA_WIDTH-1:0]        w_enc_data;
  logic                         w_enc_en;
  logic                         w_ready_nxt;
  logic                         w_rd_nxt;
  logic                         w_wr_nxt;
  logic                         w_done_nxt;
  logic [DATA_WIDTH-1:0]        w_bmask;
  logic [DATA_WIDTH-1:0]        w_merged;
  logic                         w_unused;

  assign w_bmask  = {{8{r_strb[3]}}, {8{r_strb[2]}}, {8{r_strb[1]}}, {8{r_strb[0]}}};
  // Old data is taken from the data positions as-is; no correction on this path.
  assign w_merged = (r_data & w_bmask) | (f_extract(bus.mem_rd_data_i) & ~w_bmask);
  assign w_unused = ^{ECC_en[31:1], bus.wr_addr_i[1:0]};

  always_ff @(posedge ECC_encoding_clk) begin
    if (ECC_encoding_rst) r_state <= S_IDLE;
    else                  r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_zero_done = 1'b0;
    w_enc_data  = bus.wr_data_i;
    w_enc_en    = ECC_en[0];
    case (r_state)
      S_IDLE: begin
        if (bus.wr_en_i) begin
          w_accept = 1'b1;
          if (bus.wr_strb_i == STRB_WIDTH'(4'hF))      w_state_nxt = S_WRITE;
          else if (bus.wr_strb_i == STRB_WIDTH'(4'h0)) w_zero_done = 1'b1;
          else                                         w_state_nxt = S_RD;
        end
      end
      S_RD:    w_state_nxt = S_MERGE;
      S_MERGE: begin
        w_enc_data  = w_merged;
        w_enc_en    = r_ecc_en;
        w_state_nxt = S_WRITE;
      end
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_rd_nxt    = (w_state_nxt == S_RD);
    w_wr_nxt    = (w_state_nxt == S_WRITE);
    w_done_nxt  = w_wr_nxt | w_zero_done;
  end

  // Registered outputs and request capture.
  always_ff @(posedge ECC_encoding_clk) begin
    if (ECC_encoding_rst) begin
      r_ready   <= 1'b1;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_done    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_strb    <= '0;
      r_ecc_en  <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_ready <= w_ready_nxt;
      r_rd_en <= w_rd_nxt;
      r_wr_en <= w_wr_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_addr   <= bus.wr_addr_i[ADDR_WIDTH-1:2];
        r_data   <= bus.wr_data_i;
        r_strb   <= bus.wr_strb_i;
        r_ecc_en <= ECC_en[0];
      end
      if (w_wr_nxt) r_wr_data <= f_encode(w_enc_data, w_enc_en);
    end
  end

  assign bus.wr_ready_o    = r_ready;
  assign bus.mem_rd_en_o   = r_rd_en;
  assign bus.mem_wr_en_o   = r_wr_en;
  assign bus.wr_done_o     = r_done;
  assign bus.mem_addr_o    = r_addr;
  assign bus.mem_wr_data_o = r_wr_data;

  // PARITY_BITS documents the code; the masks above are its concrete form.
  localparam int unsigned UNUSED_PARITY_BITS = PARITY_BITS;
endmodule

// File: tb/tb_ecc_encoding_wr.sv
// Directed plus randomized bench for ecc_encoding_wr with a behavioural Hamming
// model, a word-addressed memory model and a syndrome-based decoder check.
module tb_ecc_encoding_wr;
  logic        clk;
  logic        rst;
  logic [31:0] ecc_en;
  int          n_assert;
  int          n_fail;
  logic [38:0] mem [4096];

  ecc_encoding_wr_if bus ();

  ecc_encoding_wr dut (
    .ECC_encoding_clk (clk),
    .ECC_encoding_rst (rst),
    .ECC_en           (ecc_en),
    .bus              (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_pow2(input int k);
    return (k & (k - 1)) == 0;
  endfunction

  // Behavioural encoder: walk positions 1..38, fill data, then compute each parity.
  function automatic logic [38:0] ref_encode(input logic [31:0] d, input logic e);
    logic [38:0] cw;
    logic        p;
    int          j;
    cw = '0;
    j  = 0;
    for (int k = 1; k <= 38; k++) begin
      if (!is_pow2(k)) begin
        cw[6'(k)] = d[5'(j)];
        j++;
      end
    end
    if (e) begin
      for (int i = 0; i < 6; i++) begin
        p = 1'b0;
        for (int k = 1; k <= 38; k++)
          if (((k >> i) & 1) == 1) p = p ^ cw[6'(k)];
        cw[6'(1 << i)] = p;
      end
      p = 1'b0;
      for (int k = 1; k <= 38; k++) p = p ^ cw[6'(k)];
      cw[0] = p;
    end
    return cw;
  endfunction

  function automatic logic [31:0] ref_data(input logic [38:0] cw);
    logic [31:0] d;
    int          j;
    d = '0;
    j = 0;
    for (int k = 1; k <= 38; k++) begin
      if (!is_pow2(k)) begin
        d[5'(j)] = cw[6'(k)];
        j++;
      end
    end
    return d;
  endfunction

  // Decoder view: XOR of set positions plus overall parity; zero for a clean word.
  function automatic logic [6:0] ref_syndrome(input logic [38:0] cw);
    logic [5:0] s;
    logic       ov;
    s  = '0;
    ov = 1'b0;
    for (int k = 0; k <= 38; k++) begin
      if (cw[6'(k)]) s = s ^ 6'(k);
      ov = ov ^ cw[6'(k)];
    end
    return {ov, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rd, input logic wr,
                         input logic done, input logic rdy);
    chk({tag, "_rd"},   64'(bus.mem_rd_en_o), 64'(rd));
    chk({tag, "_wr"},   64'(bus.mem_wr_en_o), 64'(wr));
    chk({tag, "_done"}, 64'(bus.wr_done_o),   64'(done));
    chk({tag, "_rdy"},  64'(bus.wr_ready_o),  64'(rdy));
    chk({tag, "_excl"}, 64'(bus.mem_rd_en_o & bus.mem_wr_en_o), 64'd0);
  endtask

  // One complete request with cycle-accurate checks; the memory model answers reads.
  task automatic run_req(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic e, output logic [38:0] cw);
    logic [11:0] wa;
    logic [31:0] exp_d;
    logic [38:0] exp_cw;
    int          n;
    wa = a[13:2];
    n  = 0;
    cw = '0;
    while (bus.wr_ready_o !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("wait_ready", 64'(bus.wr_ready_o), 64'd1);
    exp_d = ref_data(mem[wa]);
    for (int b = 0; b < 4; b++)
      if (s[2'(b)]) exp_d[8*b +: 8] = d[8*b +: 8];
    exp_cw = ref_encode(exp_d, e);
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = a;
    bus.wr_data_i = d;
    bus.wr_strb_i = s;
    ecc_en        = {31'($urandom()), e};
    tick();
    bus.wr_en_i   = 1'b0;
    bus.wr_addr_i = 14'($urandom());
    bus.wr_data_i = $urandom();
    bus.wr_strb_i = 4'($urandom());
    ecc_en        = ~ecc_en;
    if (s == 4'hF) begin
      chk_out("full_n1", 1'b0, 1'b1, 1'b1, 1'b0);
      chk("full_addr", 64'(bus.mem_addr_o), 64'(wa));
      chk("full_data", 64'(bus.mem_wr_data_o), 64'(exp_cw));
      cw      = bus.mem_wr_data_o;
      mem[wa] = exp_cw;
      tick();
      chk_out("full_n2", 1'b0, 1'b0, 1'b0, 1'b1);
    end else if (s == 4'h0) begin
      chk_out("zero_n1", 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      chk_out("zero_n2", 1'b0, 1'b0, 1'b0, 1'b1);
    end else begin
      chk_out("rmw_n1", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rmw_addr1", 64'(bus.mem_addr_o), 64'(wa));
      tick();
      bus.mem_rd_data_i = mem[wa];
      chk_out("rmw_n2", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rmw_addr2", 64'(bus.mem_addr_o), 64'(wa));
      tick();
      bus.mem_rd_data_i = {7'($urandom()), $urandom()};
      chk_out("rmw_n3", 1'b0, 1'b1, 1'b1, 1'b0);
      chk("rmw_addr3", 64'(bus.mem_addr_o), 64'(wa));
      chk("rmw_data", 64'(bus.mem_wr_data_o), 64'(exp_cw));
      cw      = bus.mem_wr_data_o;
      mem[wa] = exp_cw;
      tick();
      chk_out("rmw_n4", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    if (e && s != 4'h0) chk("syndrome", 64'(ref_syndrome(cw)), 64'd0);
  endtask

  initial begin
    logic [38:0] cw;
    logic [31:0] bd [3];
    logic [2:0]  wa3;
    n_assert          = 0;
    n_fail            = 0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    rst               = 1'b1;
    ecc_en            = '0;
    bus.wr_en_i       = 1'b0;
    bus.wr_addr_i     = '0;
    bus.wr_data_i     = '0;
    bus.wr_strb_i     = '0;
    bus.mem_rd_data_i = '0;

    repeat (3) tick();
    chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_addr", 64'(bus.mem_addr_o), 64'd0);
    chk("reset_wdata", 64'(bus.mem_wr_data_o), 64'd0);
    rst = 1'b0;
    tick();

    run_req(14'h0004, 32'h0000_0001, 4'hF, 1'b1, cw);
    chk("vec_ecc_on", 64'(cw), 64'h0F);
    run_req(14'h0004, 32'h0000_0001, 4'hF, 1'b0, cw);
    chk("vec_ecc_off", 64'(cw), 64'h08);
    run_req(14'h0008, 32'h0000_0000, 4'hF, 1'b1, cw);
    chk("vec_zero", 64'(cw), 64'h0);

    run_req(14'h0100, 32'h1234_5600, 4'hF, 1'b1, cw);
    run_req(14'h0100, 32'h0000_00A5, 4'b0001, 1'b1, cw);
    chk("vec_rmw", 64'(cw), 64'(ref_encode(32'h1234_56A5, 1'b1)));

    run_req(14'h0200, $urandom(), 4'h0, 1'b1, cw);
    run_req(14'h3FFF, 32'hDEAD_BEEF, 4'hF, 1'b1, cw);

    // Reset while the RMW sits in MERGE: request must vanish.
    bus.wr_en_i   = 1'b1;
    bus.wr_addr_i = 14'h0040;
    bus.wr_data_i = 32'hCAFE_F00D;
    bus.wr_strb_i = 4'b0011;
    ecc_en        = 32'h1;
    tick();
    bus.wr_en_i   = 1'b0;
    chk_out("rstm_n1", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rstm_n2", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("rstm_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rstm_addr", 64'(bus.mem_addr_o), 64'd0);
    chk("rstm_wdata", 64'(bus.mem_wr_data_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("rstm_after", 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Back-to-back full writes with wr_en_i held: one accept every two cycles.
    for (int k = 0; k < 3; k++) bd[k] = $urandom();
    ecc_en        = 32'h1;
    bus.wr_en_i   = 1'b1;
    bus.wr_strb_i = 4'hF;
    bus.wr_addr_i = 14'h0300;
    bus.wr_data_i = bd[0];
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c % 2 == 0) begin
        chk_out("b2b_wr", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("b2b_addr", 64'(bus.mem_addr_o), 64'(12'h0C0 + 12'(c / 2)));
        chk("b2b_data", 64'(bus.mem_wr_data_o), 64'(ref_encode(bd[c / 2], 1'b1)));
        mem[12'h0C0 + 12'(c / 2)] = ref_encode(bd[c / 2], 1'b1);
        if (c < 4) begin
          bus.wr_addr_i = 14'h0300 + 14'(4 * (c / 2 + 1));
          bus.wr_data_i = bd[c / 2 + 1];
        end else begin
          bus.wr_en_i = 1'b0;
        end
      end else begin
        chk_out("b2b_idle", 1'b0, 1'b0, 1'b0, 1'b1);
      end
    end

    // Random traffic over a few words so partial writes merge real history.
    for (int i = 0; i < 40; i++) begin
      wa3 = 3'($urandom_range(0, 7));
      run_req({9'd0, wa3, 2'($urandom())}, $urandom(), 4'($urandom_range(0, 15)),
              1'($urandom()), cw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
